decode_sequencer: RTL and testbench

Pipeline controller wrapped around the combinational `decode` stage, between fetch and rename. It buffers fetched instructions in a small FIFO and presents the head entry to `decode`. It drops architectural no-ops, halts issue on an illegal instruction, and hands decoded `uop_t` words downstream through a registered valid/ready output stage. It also owns the pipeline-flush response for the fetch-to-rename boundary.

---
 rtl/decode_sequencer_if.sv | 64 ++++++
 rtl/decode_sequencer.sv | 131 +++++++++++++
 tb/tb_decode_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_sequencer_if.sv
// rtl/decode_sequencer_if.sv - shared types and fetch/decode/rename handshake bundle for decode_sequencer
//
// decode_sequencer_pkg : pc_t (32-bit PC) and uop_t (decoded micro-op carrying its PC)
// decode_sequencer_if  : signal bundle between fetch, the combinational decode stage and rename
//   fetch_valid/fetch_ready/fetch_instr/fetch_pc : entry channel from fetch
//   dec_instr/dec_pc                             : FIFO head presented to decode
//   dec_nop/dec_invalid/dec_uop                  : decode's classification of that head
//   uop_valid/uop_ready/uop_out                  : registered uop channel toward rename
//   modport slave  : the sequencer side
//   modport master : the surrounding pipeline side

package decode_sequencer_pkg;
  localparam int PC_WIDTH = 32;

  typedef logic [PC_WIDTH-1:0] pc_t;

  typedef struct packed {
    pc_t         pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } uop_t;
endpackage

interface decode_sequencer_if #(
  parameter int INSTR_WIDTH = 32
);
  import decode_sequencer_pkg::*;

  logic                   fetch_valid;
  logic                   fetch_ready;
  logic [INSTR_WIDTH-1:0] fetch_instr;
  pc_t                    fetch_pc;

  logic [INSTR_WIDTH-1:0] dec_instr;
  pc_t                    dec_pc;
  logic                   dec_nop;
  logic                   dec_invalid;
  uop_t                   dec_uop;

  logic                   uop_valid;
  logic                   uop_ready;
  uop_t                   uop_out;

  modport slave (
    input  fetch_valid, fetch_instr, fetch_pc,
    output fetch_ready,
    output dec_instr, dec_pc,
    input  dec_nop, dec_invalid, dec_uop,
    output uop_valid, uop_out,
    input  uop_ready
  );

  modport master (
    output fetch_valid, fetch_instr, fetch_pc,
    input  fetch_ready,
    input  dec_instr, dec_pc,
    output dec_nop, dec_invalid, dec_uop,
    input  uop_valid, uop_out,
    output uop_ready
  );
endinterface

// File: rtl/decode_sequencer.sv
// rtl/decode_sequencer.sv - fetch FIFO, decode sequencing and registered uop output between fetch and rename
//
// Ports:
//   clk, rst    : clock; asynchronous active-high reset
//   bus         : decode_sequencer_if.slave (fetch entry channel, decode head/classification, uop channel)
//   flush       : synchronous pipeline flush; wins over every other event in its cycle
//   exc_valid   : illegal-instruction exception pending (held until flush)
//   exc_pc      : PC of the illegal instruction
//   fifo_count  : current FIFO occupancy
//   issued_cnt  : uops loaded into the output stage since reset (wraps)

module decode_sequencer
  import decode_sequencer_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  decode_sequencer_if.slave            bus,
  input  logic                         flush,
  output logic                         exc_valid,
  output pc_t                          exc_pc,
  output logic [$clog2(QUEUE_DEPTH):0] fifo_count,
  output logic [CNT_WIDTH-1:0]         issued_cnt
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t                 state;
  logic [INSTR_WIDTH-1:0] mem_instr [QUEUE_DEPTH];
  pc_t                    mem_pc    [QUEUE_DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic                   uop_valid_q;
  uop_t                   uop_out_q;

  logic fifo_empty;
  logic fetch_ready_c;
  logic push;
  logic head_live;
  logic take_exc;
  logic take_nop;
  logic issue;
  logic pop;

  // Ready looks at the registered count only, so a same-cycle pop never
  // opens a slot early; flush blocks acceptance outright.
  assign fifo_empty    = (fifo_count == '0);
  assign fetch_ready_c = (fifo_count < CNT_W'(QUEUE_DEPTH)) && !flush;
  assign push          = bus.fetch_valid && fetch_ready_c;

  // Head classification in priority order: illegal, nop, then issue.
  // A nop is dropped even while the output stage is stalled.
  assign head_live = (state == RUN) && !fifo_empty;
  assign take_exc  = head_live && bus.dec_invalid;
  assign take_nop  = head_live && !bus.dec_invalid && bus.dec_nop;
  assign issue     = head_live && !bus.dec_invalid && !bus.dec_nop
                     && (!uop_valid_q || bus.uop_ready);
  assign pop       = take_exc || take_nop || issue;

  assign bus.fetch_ready = fetch_ready_c;
  assign bus.dec_instr   = fifo_empty ? '0 : mem_instr[rd_ptr];
  assign bus.dec_pc      = fifo_empty ? '0 : mem_pc[rd_ptr];
  assign bus.uop_valid   = uop_valid_q;
  assign bus.uop_out     = uop_out_q;

  // Entry storage needs no reset: occupancy gates everything read from it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= bus.fetch_instr;
      mem_pc[wr_ptr]    <= bus.fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      uop_valid_q <= 1'b0;
      uop_out_q   <= '0;
      exc_valid   <= 1'b0;
      exc_pc      <= '0;
      issued_cnt  <= '0;
    end else if (flush) begin
      // exc_pc and issued_cnt deliberately survive a flush.
      state       <= RUN;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
      uop_valid_q <= 1'b0;
      exc_valid   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (!push && pop) begin
        fifo_count <= fifo_count - 1'b1;
      end

      if (issue) begin
        uop_out_q   <= bus.dec_uop;
        uop_valid_q <= 1'b1;
        issued_cnt  <= issued_cnt + 1'b1;
      end else if (bus.uop_ready) begin
        uop_valid_q <= 1'b0;
      end

      if (take_exc) begin
        exc_valid <= 1'b1;
        exc_pc    <= bus.dec_pc;
        state     <= HALT;
      end
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// tb/tb_decode_sequencer.sv - scoreboard bench for decode_sequencer with a decode stub and random stream

module tb_decode_sequencer;
  import decode_sequencer_pkg::*;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        exc_valid;
  pc_t         exc_pc;
  logic [2:0]  fifo_count;
  logic [31:0] issued_cnt;

  decode_sequencer_if #(.INSTR_WIDTH(32)) bus ();

  decode_sequencer #(
    .INSTR_WIDTH(32),
    .QUEUE_DEPTH(QD),
    .CNT_WIDTH  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flush     (flush),
    .exc_valid (exc_valid),
    .exc_pc    (exc_pc),
    .fifo_count(fifo_count),
    .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  // Decode stage stand-in: RV32-style, anything not ending in 2'b11 or all-ones is illegal.
  function automatic logic is_illegal(input logic [31:0] i);
    return (i == 32'hFFFF_FFFF) || (i[1:0] != 2'b11);
  endfunction

  function automatic logic is_nop(input logic [31:0] i);
    return i == 32'h0000_0013;
  endfunction

  function automatic uop_t make_uop(input logic [31:0] i, input pc_t pc);
    uop_t u;
    u.pc     = pc;
    u.opcode = i[6:0];
    u.rd     = i[11:7];
    u.rs1    = i[19:15];
    u.rs2    = i[24:20];
    u.imm    = {{20{i[31]}}, i[31:20]};
    return u;
  endfunction

  always_comb begin
    bus.dec_invalid = is_illegal(bus.dec_instr);
    bus.dec_nop     = is_nop(bus.dec_instr);
    bus.dec_uop     = make_uop(bus.dec_instr, bus.dec_pc);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: accepted entries in order; everything after the first
  // illegal entry of a flush epoch is dead, nops vanish, the rest must appear
  // on the uop channel in order.
  uop_t exp_q[$];
  int   model_issued   = 0;
  int   flushed_issued = 0;
  bit   halted         = 1'b0;
  pc_t  model_exc_pc   = '0;
  bit   exc_seen       = 1'b0;
  bit   hold_prev      = 1'b0;
  uop_t hold_uop;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_issued = 0;
      halted       = 1'b0;
      model_exc_pc = '0;
      exc_seen     = 1'b0;
      hold_prev    = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      halted    = 1'b0;
      exc_seen  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", bus.uop_valid, 1'b1);
        check("hold_uop", bus.uop_out, hold_uop);
      end
      if (bus.uop_valid && bus.uop_ready) begin
        check("uop_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check("uop_out", bus.uop_out, exp_q.pop_front());
          model_issued++;
        end
      end
      hold_prev = bus.uop_valid && !bus.uop_ready;
      hold_uop  = bus.uop_out;
      if (exc_valid && !exc_seen) begin
        check("exc_expected", halted, 1'b1);
        check("exc_pc", exc_pc, model_exc_pc);
        exc_seen = 1'b1;
      end
      if (bus.fetch_valid && bus.fetch_ready && !halted) begin
        if (is_illegal(bus.fetch_instr)) begin
          halted       = 1'b1;
          model_exc_pc = bus.fetch_pc;
        end else if (!is_nop(bus.fetch_instr)) begin
          exp_q.push_back(make_uop(bus.fetch_instr, bus.fetch_pc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input pc_t pc);
    bit acc = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = i;
    bus.fetch_pc    = pc;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = bus.fetch_ready;
      tick();
    end
    check("send_accepted", acc, 1'b1);
    bus.fetch_valid = 1'b0;
  endtask

  // Offers addi entries back to back for n_cycles; returns how many were taken.
  task automatic push_burst(input int n_cycles, input pc_t base, output int acc_n);
    acc_n = 0;
    for (int n = 0; n < n_cycles; n++) begin
      bus.fetch_valid = 1'b1;
      bus.fetch_instr = 32'h0000_0093 | (32'(acc_n) << 20);
      bus.fetch_pc    = base + 32'(4 * acc_n);
      @(negedge clk);
      if (bus.fetch_ready) acc_n++;
      tick();
    end
    bus.fetch_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.uop_ready   = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      tick();
      done = !bus.uop_valid && (fifo_count == 0 || exc_valid);
    end
    check("drain_done", done, 1'b1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_fetch_ready"}, bus.fetch_ready, 1'b1);
    check({tag, "_uop_valid"}, bus.uop_valid, 1'b0);
    check({tag, "_uop_out"}, bus.uop_out, '0);
    check({tag, "_exc_valid"}, exc_valid, 1'b0);
    check({tag, "_exc_pc"}, exc_pc, '0);
    check({tag, "_fifo_count"}, fifo_count, '0);
    check({tag, "_issued_cnt"}, issued_cnt, '0);
    check({tag, "_dec_instr"}, bus.dec_instr, '0);
    check({tag, "_dec_pc"}, bus.dec_pc, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc_n;
    int          r;
    logic [31:0] instr;
    pc_t         pc_ctr;

    bus.fetch_valid = 1'b0;
    bus.fetch_instr = '0;
    bus.fetch_pc    = '0;
    bus.uop_ready   = 1'b0;
    flush           = 1'b0;
    rst             = 1'b1;
    tick();
    reset_checks("reset");
    tick();
    rst = 1'b0;
    tick();

    // Streaming: two edges of latency, then back-to-back uops.
    bus.uop_ready = 1'b1;
    send(32'h0050_0093, 32'h100);
    check("stream_count_after_push", fifo_count, 3'd1);
    send(32'h0010_8133, 32'h104);
    check("stream_first_valid", bus.uop_valid, 1'b1);
    check("stream_first_pc", bus.uop_out.pc, 32'h100);
    tick();
    check("stream_second_valid", bus.uop_valid, 1'b1);
    check("stream_second_pc", bus.uop_out.pc, 32'h104);
    tick();
    check("stream_idle", bus.uop_valid, 1'b0);
    check("stream_issued", issued_cnt, 32'd2);

    // Nop drop: one bubble cycle, only two uops.
    send(32'h00a0_0113, 32'h110);
    send(32'h0000_0013, 32'h114);
    check("nop_a_valid", bus.uop_valid, 1'b1);
    check("nop_a_pc", bus.uop_out.pc, 32'h110);
    send(32'h0020_8193, 32'h118);
    check("nop_bubble", bus.uop_valid, 1'b0);
    tick();
    check("nop_b_valid", bus.uop_valid, 1'b1);
    check("nop_b_pc", bus.uop_out.pc, 32'h118);
    tick();
    check("nop_issued", issued_cnt, 32'd4);

    // Backpressure: one held uop plus a full FIFO; the sixth entry is refused.
    bus.uop_ready = 1'b0;
    push_burst(10, 32'h300, acc_n);
    check("bp_accepted", acc_n, 5);
    check("bp_fifo_full", fifo_count, 3'd4);
    check("bp_fetch_ready", bus.fetch_ready, 1'b0);
    check("bp_held_valid", bus.uop_valid, 1'b1);
    check("bp_held_pc", bus.uop_out.pc, 32'h300);
    drain();
    check("bp_drained", exp_q.size(), 0);
    check("bp_issued", issued_cnt, 32'(model_issued + flushed_issued));

    // Illegal instruction: halt, keep filling, flush back to RUN.
    bus.uop_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'h200);
    tick();
    check("ill_exc_valid", exc_valid, 1'b1);
    check("ill_exc_pc", exc_pc, 32'h200);
    push_burst(8, 32'h210, acc_n);
    check("ill_accepted", acc_n, 4);
    check("ill_fifo_full", fifo_count, 3'd4);
    check("ill_no_uop", bus.uop_valid, 1'b0);
    check("ill_issued", issued_cnt, 32'(model_issued + flushed_issued));
    flush = 1'b1;
    bus.fetch_valid = 1'b1;
    tick();
    flush = 1'b0;
    bus.fetch_valid = 1'b0;
    check("ill_flush_count", fifo_count, 3'd0);
    check("ill_flush_exc", exc_valid, 1'b0);
    check("ill_flush_exc_pc_hold", exc_pc, 32'h200);
    send(32'h0050_0093, 32'h240);
    drain();
    check("ill_resume_issued", issued_cnt, 32'(model_issued + flushed_issued));

    // Flush priority: push, issue-eligible head and flush in the same cycle.
    bus.uop_ready = 1'b0;
    send(32'h0010_0093, 32'h400);
    send(32'h0020_0093, 32'h404);
    flush           = 1'b1;
    bus.uop_ready   = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.fetch_instr = 32'h0030_0093;
    bus.fetch_pc    = 32'h408;
    @(negedge clk);
    check("fp_fetch_ready", bus.fetch_ready, 1'b0);
    tick();
    flush           = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.uop_ready   = 1'b0;
    flushed_issued++;
    check("fp_uop_valid", bus.uop_valid, 1'b0);
    check("fp_fifo_count", fifo_count, 3'd0);
    check("fp_issued", issued_cnt, 32'(model_issued + flushed_issued));
    tick();
    check("fp_still_idle", bus.uop_valid, 1'b0);

    // Reset mid-stream: three queued entries and a held uop.
    send(32'h0010_0093, 32'h500);
    send(32'h0020_0093, 32'h504);
    send(32'h0030_0093, 32'h508);
    send(32'h0040_0093, 32'h50c);
    check("mid_count", fifo_count, 3'd3);
    check("mid_valid", bus.uop_valid, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    flushed_issued = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Random stream in flush-separated epochs.
    pc_ctr = 32'h1000;
    for (int ep = 0; ep < 8; ep++) begin
      for (int c = 0; c < 60; c++) begin
        r = $urandom_range(0, 99);
        if (r < 20) begin
          instr = 32'h0000_0013;
        end else if (r < 21) begin
          instr = 32'hFFFF_FFFF;
        end else begin
          instr = $urandom();
          instr[1:0] = 2'b11;
          if (instr == 32'hFFFF_FFFF) instr = 32'h0000_0093;
        end
        bus.fetch_valid = ($urandom_range(0, 9) < 7);
        bus.fetch_instr = instr;
        bus.fetch_pc    = pc_ctr;
        pc_ctr          = pc_ctr + 32'd4;
        bus.uop_ready   = ($urandom_range(0, 9) < 6);
        tick();
      end
      drain();
      check("ep_all_seen", exp_q.size(), 0);
      check("ep_issued", issued_cnt, 32'(model_issued + flushed_issued));
      check("ep_exc", exc_valid, halted);
      bus.uop_ready = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("ep_flush_count", fifo_count, 3'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
